// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters
// and returns the captured result and flags on a tagged response channel.
module alu_rr_arbiter #(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_opcode,
  input  logic [NUMBITS-1:0] req0_a,
  input  logic [NUMBITS-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_opcode,
  input  logic [NUMBITS-1:0] req1_a,
  input  logic [NUMBITS-1:0] req1_b,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [NUMBITS-1:0] rsp_result,
  output logic [2:0]         rsp_flags,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant_id;
  logic   accept;

  // On contention the requester that did not win last time goes first.
  assign grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign accept     = (state == IDLE) & (req0_valid | req1_valid);
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // last_grant doubles as the owner of the in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        alu_a      <= grant_id ? req1_a      : req0_a;
        alu_b      <= grant_id ? req1_b      : req0_b;
        alu_opcode <= grant_id ? req1_opcode : req0_opcode;
      end
      if (state == CAPTURE) begin
        rsp_id     <= last_grant;
        rsp_result <= alu_result;
        rsp_flags  <= {alu_carryout, alu_overflow, alu_zero};
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a behavioural registered ALU
// and a reference round-robin model predicting grants and responses.
module tb_alu_rr_arbiter;

  typedef struct {
    logic        id;
    logic [15:0] result;
    logic [2:0]  flags;
  } rspT;

  logic        clk;
  logic        rstN;
  logic        req0Valid, req1Valid;
  logic        req0Ready, req1Ready;
  logic [2:0]  req0Opcode, req1Opcode;
  logic [15:0] req0A, req0B, req1A, req1B;
  logic [15:0] aluA, aluB;
  logic [2:0]  aluOpcode;
  logic [15:0] aluResult;
  logic        aluCarry, aluOvf, aluZero;
  logic        rspValid, rspReady, rspId;
  logic [15:0] rspResult;
  logic [2:0]  rspFlags;
  logic        busy;

  rspT  expQ[$];
  logic modelLast;
  int   compareCount;
  int   mismatchCount;

  alu_rr_arbiter #(.NUMBITS(16)) dut (
    .clk(clk), .reset(rstN),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_opcode(req0Opcode),
    .req0_a(req0A), .req0_b(req0B),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_opcode(req1Opcode),
    .req1_a(req1A), .req1_b(req1B),
    .alu_a(aluA), .alu_b(aluB), .alu_opcode(aluOpcode),
    .alu_result(aluResult), .alu_carryout(aluCarry), .alu_overflow(aluOvf),
    .alu_zero(aluZero),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_result(rspResult), .rsp_flags(rspFlags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, overflow, zero, result}.
  function automatic logic [18:0] aluFn(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] wide;
    logic [15:0] r;
    logic        c, o;
    wide = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[15:0]; c = wide[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[15:0]; c = wide[16];
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = a | b;
      3'd3: r = ~a;
      3'd4: r = a & b;
      3'd5: r = a << b[3:0];
      3'd6: r = a ^ b;
      default: r = a >> b[3:0];
    endcase
    return {c, o, (r == 16'h0000), r};
  endfunction

  always @(posedge clk) {aluCarry, aluOvf, aluZero, aluResult} <= aluFn(aluOpcode, aluA, aluB);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [15:0] a0,
                               input logic [15:0] b0, input logic v1, input logic [2:0] op1,
                               input logic [15:0] a1, input logic [15:0] b1);
    req0Valid = v0; req0Opcode = op0; req0A = a0; req0B = b0;
    req1Valid = v1; req1Opcode = op1; req1A = a1; req1B = b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idleRspValid", rspValid, 0);
      checkOutput("idleBusy", busy, 0);
    end
  endtask

  // One arbitration round, entered at a negedge with inputs already driven.
  task automatic arbRound(input int stallCycles, input bit changeOperand, input bit resetInCapture);
    logic        expId;
    logic [2:0]  expOp;
    logic [15:0] expA, expB;
    logic [18:0] r;
    rspT         e;
    int          waitCycles;
    bit          seen;
    #1;
    expId = (req0Valid && req1Valid) ? ~modelLast : (req1Valid && !req0Valid);
    checkOutput("ready0", req0Ready, !expId);
    checkOutput("ready1", req1Ready, expId);
    expOp = expId ? req1Opcode : req0Opcode;
    expA  = expId ? req1A : req0A;
    expB  = expId ? req1B : req0B;
    r = aluFn(expOp, expA, expB);
    e.id = expId; e.result = r[15:0]; e.flags = r[18:16];
    expQ.push_back(e);
    modelLast = expId;

    @(negedge clk);
    checkOutput("issueAluA", aluA, expA);
    checkOutput("issueAluB", aluB, expB);
    checkOutput("issueAluOp", aluOpcode, expOp);
    checkOutput("issueReadies", {req0Ready, req1Ready}, 2'b00);
    checkOutput("issueBusy", busy, 1);
    if (changeOperand) begin
      req1A = 16'h0100;
      req0A = ~req0A;
    end

    @(negedge clk);
    checkOutput("captAluA", aluA, expA);
    if (resetInCapture) begin
      rstN = 1'b0;
      #1;
      checkOutput("rstAluA", aluA, 0);
      checkOutput("rstAluB", aluB, 0);
      checkOutput("rstAluOp", aluOpcode, 0);
      checkOutput("rstRspValid", rspValid, 0);
      checkOutput("rstRsp", {rspId, rspResult, rspFlags}, 0);
      checkOutput("rstBusy", busy, 0);
      void'(expQ.pop_back());
      modelLast = 1'b1;
      @(negedge clk);
      rstN = 1'b1;
      return;
    end
    checkOutput("rspValidEarly", rspValid, 0);

    waitCycles = 0;
    seen = 0;
    while (!seen && waitCycles < 8) begin
      @(negedge clk);
      waitCycles++;
      if (rspValid) seen = 1;
    end
    if (!seen) begin
      checkOutput("rspTimeout", 0, 1);
      void'(expQ.pop_front());
      return;
    end
    checkOutput("rspLatency", waitCycles, 1);
    e = expQ.pop_front();
    checkOutput("rspId", rspId, e.id);
    checkOutput("rspResult", rspResult, e.result);
    checkOutput("rspFlags", rspFlags, e.flags);

    if (stallCycles > 0) begin
      rspReady = 1'b0;
      for (int i = 0; i < stallCycles; i++) begin
        @(negedge clk);
        checkOutput("stallValid", rspValid, 1);
        checkOutput("stallRsp", {rspId, rspResult, rspFlags}, {e.id, e.result, e.flags});
        checkOutput("stallBusy", busy, 1);
        checkOutput("stallReadies", {req0Ready, req1Ready}, 2'b00);
      end
      rspReady = 1'b1;
    end

    @(negedge clk);
    checkOutput("backToIdle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    compareCount = 0;
    mismatchCount = 0;
    modelLast = 1'b1;
    rstN = 1'b0;
    rspReady = 1'b1;
    applyStimulus(0, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    checkOutput("resetAlu", {aluA, aluB, aluOpcode}, 0);
    checkOutput("resetRsp", {rspValid, rspId, rspResult, rspFlags}, 0);
    checkOutput("resetBusy", busy, 0);
    rstN = 1'b1;
    idleCycles(2);

    $display("[TB] lone requester 0, add with carry and zero");
    applyStimulus(1, 3'b000, 16'hFFFF, 16'h0001, 0, 3'd0, 16'h0, 16'h0);
    arbRound(0, 0, 0);

    $display("[TB] both requesters continuously valid");
    applyStimulus(1, 3'b100, 16'h00F0, 16'h0FF0, 1, 3'b110, 16'hAAAA, 16'h5555);
    repeat (4) arbRound(0, 0, 0);

    $display("[TB] response stall for 10 cycles");
    arbRound(10, 0, 0);
    arbRound(0, 0, 0);

    $display("[TB] operand change after accept");
    applyStimulus(0, 3'd0, 16'h0, 16'h0, 1, 3'b111, 16'h0004, 16'h0002);
    arbRound(0, 1, 0);

    $display("[TB] lone requester 1 for three rounds, then contention");
    applyStimulus(0, 3'd0, 16'h0, 16'h0, 1, 3'b001, 16'h1234, 16'h0234);
    repeat (3) arbRound(0, 0, 0);
    applyStimulus(1, 3'b001, 16'h8000, 16'h0001, 1, 3'b001, 16'h1234, 16'h0234);
    arbRound(0, 0, 0);

    $display("[TB] random valid patterns across all opcodes");
    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(1, 3);
      applyStimulus(v[0], 3'(i), 16'($urandom), 16'($urandom),
                    v[1], 3'(7 - i), 16'($urandom), 16'($urandom));
      arbRound(0, 0, 0);
    end

    $display("[TB] reset during capture");
    applyStimulus(1, 3'b010, 16'h1200, 16'h0034, 0, 3'd0, 16'h0, 16'h0);
    arbRound(0, 0, 1);
    applyStimulus(0, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 16'h0);
    idleCycles(4);
    applyStimulus(1, 3'b011, 16'h00FF, 16'h0, 1, 3'b000, 16'h7FFF, 16'h0001);
    arbRound(0, 0, 0);
    applyStimulus(0, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 16'h0);
    idleCycles(2);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one registered 16-bit ALU (one-cycle registered latency, opcodes 000-111) between two requesters.
- Requesters win the ALU in round-robin order. Each requester uses a valid/ready handshake.
- The block latches the winning request, drives the ALU, and captures result and flags.
- It returns them on a shared response channel tagged with the requester ID.
- Position: between the two issuing units (e.g. address-gen and execute) and the single ALU instance.

Parameters:
- NUMBITS, 16, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 request accepted this cycle (combinational).
- req0_opcode  in  3  requester 0 ALU opcode.
- req0_a  in  NUMBITS  requester 0 operand A.
- req0_b  in  NUMBITS  requester 0 operand B.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as requester 0, for requester 1.
- alu_a  out  NUMBITS  operand A to ALU (registered).
- alu_b  out  NUMBITS  operand B to ALU (registered).
- alu_opcode  out  3  opcode to ALU (registered).
- alu_result  in  NUMBITS  ALU registered result.
- alu_carryout  in  1  ALU carry flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  NUMBITS  captured result.
- rsp_flags  out  3  {carryout, overflow, zero}, captured.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - alu_a/alu_b/alu_opcode=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0.
- Reset mid-operation drops the in-flight op silently; no response is ever produced for it.
- FSM states:
  - IDLE:
    - Arbitrate. If both valid, grant the requester != last_grant; otherwise grant whichever is valid.
    - reqX_ready=1 only for the granted requester, only in IDLE. Both readies are 0 in every other state.
    - On handshake: latch opcode/a/b into alu_* registers, record owner id, update last_grant, go to ISSUE.
    - No valid: stay IDLE.
  - ISSUE: alu_* held stable; the ALU registers its output at the end of this cycle. Go to CAPTURE.
  - CAPTURE: sample alu_result and the three flags into rsp_result/rsp_flags, set rsp_id=owner. Go to RESP.
  - RESP:
    - rsp_valid=1. rsp_* hold stable until rsp_valid & rsp_ready.
    - On that handshake: clear rsp_valid and go to IDLE.
    - rsp_ready low stalls indefinitely; no new request is accepted while stalled.
- Latency: accept edge (cycle N) -> rsp_valid high in cycle N+3 -> earliest next accept in cycle N+4 if rsp_ready=1 in N+3. Peak throughput 1 op / 4 cycles.
- alu_* keep their last values outside ISSUE; they change only on an accept.
- No arithmetic is done in this block. ALU flags pass through unmodified; all 8 opcodes are legal and forwarded as-is.
- A requester dropping valid before ready is legal; it is simply not granted.
- Operands are sampled only on the handshake edge. Later changes to reqX_* do not affect the in-flight op.
- Simultaneous requests on consecutive arbitration rounds alternate 0,1,0,1… A lone requester is granted every round regardless of last_grant.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Reset, then req0 only: opcode 000, a=0xFFFF, b=0x0001 -> req0_ready pulses 1 cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x0000, rsp_flags=3'b101.
- req0 and req1 both valid continuously (req0: 100, 0x00F0&0x0FF0; req1: 110, 0xAAAA^0x5555), rsp_ready=1 -> grants alternate 0,1,0,1. Responses: id0 result 0x00F0 flags 000; id1 result 0xFFFF flags 000. One accept every 4 cycles.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, busy=1, both reqX_ready stay 0; release -> IDLE next cycle, next grant proceeds.
- Change req1_a from 0x0004 to 0x0100 the cycle after accept (opcode 111) -> response still 0x0001 (0x0004>>2), zero=0.
- Assert reset=0 during CAPTURE -> all outputs 0 immediately (async); after release no rsp_valid for the dropped op; first grant goes to requester 0.
- Only req1 valid for 3 rounds -> req1 granted each round; then both valid -> requester 0 granted.
